eth_tx_arb: RTL and testbench
=============================

Name: eth_tx_arb

Overview:
Frame-granular round-robin arbiter that shares the single Ethernet RMII transmit byte path between pNum_Req frame sources, for example an ARP responder and a UDP/IP packet builder.
- Sits between the frame sources and the TX byte serializer.
- Locks the grant for a whole frame.
- Enforces the inter-packet gap (IPG) before the next grant.
- Aborts frames that exceed the maximum frame length.

Parameters:
pNum_Req, 2, number of requesters (2..8)
pIPG_Cnt, 48, IPG length in Clk cycles (12 bytes x 8 bits / 2-bit RMII)
pMax_Frame_Bytes, 1518, maximum bytes per grant before forced abort

Ports:
Clk  input  1  RMII reference clock (50 MHz)
Rst  input  1  synchronous active-high reset
Req_Vld  input  pNum_Req  per-requester byte valid; a high level also means "requesting"
Req_Byte  input  8*pNum_Req  per-requester byte; requester i occupies bits [8i+7:8i]
Req_Last  input  pNum_Req  per-requester last-byte-of-frame flag, qualified by Req_Vld
Req_Rdy  output  pNum_Req  per-requester byte accepted
Grant  output  pNum_Req  one-hot current owner, registered
Tx_Vld  output  1  byte valid to serializer
Tx_Byte  output  8  byte to serializer
Tx_Last  output  1  last byte of frame
Tx_Rdy  input  1  serializer accepts byte
Tx_Abort  output  1  one-cycle pulse when a frame is truncated
Busy  output  1  high in ARB_GRANT or ARB_IPG

Behaviour:
- Reset values: Grant=0, Tx_Abort=0, Busy=0, state ARB_IDLE, byte count 0, IPG count 0, rLast_Grant=pNum_Req-1 (so requester 0 wins first after reset).
- Datapath mux is combinational from the registered Grant:
  - Tx_Vld = Req_Vld[g] & grant active
  - Tx_Byte = Req_Byte[g]
  - Tx_Last = Req_Last[g]
  - Req_Rdy[i] = Tx_Rdy & Grant[i]
  - Zero-cycle latency through the mux.
  - With Grant=0: Tx_Vld=0, Req_Rdy=0, Tx_Byte=0, Tx_Last=0.
- Transfer occurs when Tx_Vld & Tx_Rdy are both high.
- ARB_IDLE (0):
  - If any Req_Vld bit is high, select the first set bit searching upward from rLast_Grant+1, wrapping modulo pNum_Req.
  - Register Grant one-hot and rLast_Grant=index.
  - Clear the byte count and go to ARB_GRANT.
  - Grant is therefore visible one cycle after Req_Vld rises.
- ARB_GRANT (1):
  - Each transfer increments the 16-bit byte count.
  - Transfer with Tx_Last=1: clear Grant, load the IPG count with 0, go to ARB_IPG.
  - Transfer where the count reaches pMax_Frame_Bytes-1 without Tx_Last: pulse Tx_Abort for one cycle, clear Grant, go to ARB_IPG. The granted requester must discard the remainder of its frame.
  - If the owner drops Req_Vld mid-frame, the grant is held. No timeout; it waits indefinitely for Tx_Last.
  - Requests from other requesters during the grant are ignored; they are not latched.
- ARB_IPG (2):
  - The IPG count increments every cycle. When the count equals pIPG_Cnt-1, go to ARB_IDLE.
  - This gives exactly pIPG_Cnt cycles with Grant=0.
  - Requests are ignored in this state.
- Default or illegal state: go to ARB_IDLE with Grant=0.
- Simultaneous events:
  - Tx_Last and the max-length condition on the same transfer: treated as normal completion; Tx_Abort stays 0.
  - All requesters asserting in ARB_IDLE: the round-robin pointer guarantees fairness, with each requester granted at most once per pNum_Req frames while others wait.
- Reset mid-frame: Grant is cleared on the next edge, Tx_Vld falls the same cycle as Grant, and no abort pulse is generated.
- Single requester with back-to-back frames: consecutive grants are separated by exactly pIPG_Cnt+1 cycles (IPG plus the IDLE arbitration cycle).

Test Plan:
- Reset, then Req_Vld=01 with a 64-byte frame and Tx_Rdy=1 -> Grant=01 one cycle later; 64 transfers; Tx_Last on byte 64; Grant=00 for 48 cycles; Busy low afterwards.
- Req_Vld=11 held continuously, 60-byte frames -> grant order 01,10,01,10; each frame separated by 48 IPG cycles plus 1 arbitration cycle.
- Tx_Rdy toggled 1/0 every cycle during a 10-byte frame -> exactly 10 Req_Rdy pulses to the owner; Tx_Byte matches the source sequence; no byte duplicated or dropped.
- Owner drops Req_Vld for 5 cycles mid-frame while requester 1 asserts -> Grant stays 01; Tx_Vld=0 during the gap; frame completes normally.
- pMax_Frame_Bytes=16 and a frame with no Tx_Last -> Tx_Abort single pulse on the 16th transfer; Grant=00; 48 IPG cycles follow.
- Assert Rst during byte 20 of a frame -> next cycle Grant=00, Tx_Vld=0, Tx_Abort=0; after release, requester 0 wins first.

Source files
------------

// File: rtl/eth_tx_arb.sv
// Frame-granular round-robin arbiter sharing one RMII TX byte path between
// pNum_Req sources, with inter-packet gap and max-length abort.
module eth_tx_arb #(
  parameter int pNum_Req         = 2,
  parameter int pIPG_Cnt         = 48,
  parameter int pMax_Frame_Bytes = 1518
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [pNum_Req-1:0]   Req_Vld,
  input  logic [8*pNum_Req-1:0] Req_Byte,
  input  logic [pNum_Req-1:0]   Req_Last,
  output logic [pNum_Req-1:0]   Req_Rdy,
  output logic [pNum_Req-1:0]   Grant,
  output logic                  Tx_Vld,
  output logic [7:0]            Tx_Byte,
  output logic                  Tx_Last,
  input  logic                  Tx_Rdy,
  output logic                  Tx_Abort,
  output logic                  Busy
);
  localparam int IW = (pNum_Req > 1) ? $clog2(pNum_Req) : 1;
  localparam logic [15:0]   MAX_M1   = 16'(pMax_Frame_Bytes - 1);
  localparam logic [15:0]   IPG_M1   = 16'(pIPG_Cnt - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(pNum_Req - 1);
  localparam logic [pNum_Req-1:0] ONE = {{(pNum_Req-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_IPG   = 2'd2
  } arb_state_t;

  arb_state_t          r_state, w_state_nxt;
  logic [pNum_Req-1:0] r_grant, w_grant_nxt;
  logic [IW-1:0]       r_last_grant, w_last_nxt;
  logic [15:0]         r_byte_cnt, w_byte_cnt_nxt;
  logic [15:0]         r_ipg_cnt, w_ipg_cnt_nxt;
  logic                r_abort, w_abort_nxt;
  logic                w_found, w_xfer;
  logic [IW-1:0]       w_pick, w_idx;

  function automatic logic [IW-1:0] f_wrap(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= pNum_Req) s = s - pNum_Req;
    return IW'(s);
  endfunction

  // Search upward from the previous owner so the last winner is tried last.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_last_grant;
    w_idx   = r_last_grant;
    for (int k = 1; k <= pNum_Req; k++) begin
      w_idx = f_wrap(r_last_grant, k);
      if (!w_found && Req_Vld[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    Tx_Vld  = 1'b0;
    Tx_Byte = 8'd0;
    Tx_Last = 1'b0;
    for (int i = 0; i < pNum_Req; i++) begin
      Tx_Vld  = Tx_Vld  | (r_grant[i] & Req_Vld[i]);
      Tx_Byte = Tx_Byte | ({8{r_grant[i]}} & Req_Byte[8*i +: 8]);
      Tx_Last = Tx_Last | (r_grant[i] & Req_Last[i]);
    end
  end

  assign Req_Rdy  = {pNum_Req{Tx_Rdy}} & r_grant;
  assign Grant    = r_grant;
  assign Tx_Abort = r_abort;
  assign Busy     = (r_state == ARB_GRANT) || (r_state == ARB_IPG);
  assign w_xfer   = Tx_Vld & Tx_Rdy;

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_last_nxt     = r_last_grant;
    w_byte_cnt_nxt = r_byte_cnt;
    w_ipg_cnt_nxt  = r_ipg_cnt;
    w_abort_nxt    = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_grant_nxt = '0;
        if (w_found) begin
          w_grant_nxt    = ONE << w_pick;
          w_last_nxt     = w_pick;
          w_byte_cnt_nxt = 16'd0;
          w_state_nxt    = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        // Owner may stall indefinitely; only a transfer moves the frame along.
        if (w_xfer) begin
          w_byte_cnt_nxt = r_byte_cnt + 16'd1;
          if (Tx_Last || (r_byte_cnt == MAX_M1)) begin
            w_abort_nxt   = !Tx_Last;
            w_grant_nxt   = '0;
            w_ipg_cnt_nxt = 16'd0;
            w_state_nxt   = ARB_IPG;
          end
        end
      end
      ARB_IPG: begin
        w_grant_nxt   = '0;
        w_ipg_cnt_nxt = r_ipg_cnt + 16'd1;
        if (r_ipg_cnt == IPG_M1) w_state_nxt = ARB_IDLE;
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= ARB_IDLE;
      r_grant      <= '0;
      r_last_grant <= LAST_IDX;
      r_byte_cnt   <= 16'd0;
      r_ipg_cnt    <= 16'd0;
      r_abort      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_nxt;
      r_byte_cnt   <= w_byte_cnt_nxt;
      r_ipg_cnt    <= w_ipg_cnt_nxt;
      r_abort      <= w_abort_nxt;
    end
  end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Randomized bench for eth_tx_arb: frame sources plus an owner/gap reference
// model checked every cycle, with directed scenarios around it.
module tb_eth_tx_arb;
  localparam int N    = 3;
  localparam int IPG  = 48;
  localparam int MAXB = 70;

  logic           Clk = 1'b0;
  logic           Rst;
  logic [N-1:0]   Req_Vld, Req_Last, Req_Rdy, Grant;
  logic [8*N-1:0] Req_Byte;
  logic           Tx_Vld, Tx_Last, Tx_Rdy, Tx_Abort, Busy;
  logic [7:0]     Tx_Byte;

  eth_tx_arb #(.pNum_Req(N), .pIPG_Cnt(IPG), .pMax_Frame_Bytes(MAXB)) u_dut (
    .Clk(Clk), .Rst(Rst), .Req_Vld(Req_Vld), .Req_Byte(Req_Byte), .Req_Last(Req_Last),
    .Req_Rdy(Req_Rdy), .Grant(Grant), .Tx_Vld(Tx_Vld), .Tx_Byte(Tx_Byte),
    .Tx_Last(Tx_Last), .Tx_Rdy(Tx_Rdy), .Tx_Abort(Tx_Abort), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int n_chk, n_pass, cyc, rdy_pulses, ab_cnt, rdy_mode;
  bit rnd_mode;
  int s_len[N], s_pos[N], s_base[N], s_hold[N], s_auto[N];
  bit s_act[N], s_nolast[N];
  int m_own, m_cnt, m_quiet, m_ptr;
  bit m_abort;
  int g_log[$], g_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
  endtask

  task automatic start(input int i, input int len, input bit nolast);
    s_act[i] = 1'b1; s_len[i] = len; s_pos[i] = 0; s_nolast[i] = nolast;
    s_base[i] = int'($urandom_range(0, 255)); s_hold[i] = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      Req_Vld[i]         = s_act[i] && s_hold[i] == 0;
      Req_Byte[8*i +: 8] = 8'(s_base[i] + s_pos[i]);
      Req_Last[i]        = s_act[i] && !s_nolast[i] && (s_pos[i] == s_len[i] - 1);
    end
    case (rdy_mode)
      0:       Tx_Rdy = 1'b1;
      1:       Tx_Rdy = ~Tx_Rdy;
      default: Tx_Rdy = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  // One clock: drive, check against the model at negedge, advance at posedge.
  task automatic cycle();
    logic [N-1:0] e_gnt;
    int o, xo, n_own, n_cnt, n_quiet, n_ptr, n_new;
    bit xl, n_abort;
    drive();
    @(negedge Clk);
    o = m_own;
    e_gnt = '0;
    if (o >= 0) e_gnt[o] = 1'b1;
    chk("grant",   Grant,    e_gnt);
    chk("busy",    Busy,     (o >= 0) || (m_quiet > 0));
    chk("abort",   Tx_Abort, m_abort);
    chk("req_rdy", Req_Rdy,  Tx_Rdy ? e_gnt : '0);
    chk("tx_vld",  Tx_Vld,   o >= 0 && s_act[o] && s_hold[o] == 0);
    chk("tx_byte", Tx_Byte,  (o >= 0) ? 8'(s_base[o] + s_pos[o]) : 8'd0);
    chk("tx_last", Tx_Last,  o >= 0 && s_act[o] && !s_nolast[o] && s_pos[o] == s_len[o] - 1);
    if (Req_Rdy[0] && Req_Vld[0]) rdy_pulses++;
    if (Tx_Abort) ab_cnt++;

    n_own = m_own; n_cnt = m_cnt; n_quiet = m_quiet; n_ptr = m_ptr;
    n_abort = 1'b0; xo = -1; xl = 1'b0; n_new = -1;
    if (Rst) begin
      n_own = -1; n_cnt = 0; n_quiet = 0; n_ptr = N - 1;
    end else if (o >= 0) begin
      if (Req_Vld[o] && Tx_Rdy) begin
        xo = o; xl = Req_Last[o]; n_cnt = m_cnt + 1;
        if (xl) begin
          n_own = -1; n_quiet = IPG;
        end else if (n_cnt == MAXB) begin
          n_abort = 1'b1; n_own = -1; n_quiet = IPG;
        end
      end
    end else if (m_quiet > 0) begin
      n_quiet = m_quiet - 1;
    end else begin
      for (int k = 1; k <= N; k++)
        if (n_new < 0 && Req_Vld[(m_ptr + k) % N]) n_new = (m_ptr + k) % N;
      if (n_new >= 0) begin
        n_own = n_new; n_ptr = n_new; n_cnt = 0;
      end
    end

    @(posedge Clk);
    #1;
    cyc++;
    m_own = n_own; m_cnt = n_cnt; m_quiet = n_quiet; m_ptr = n_ptr; m_abort = n_abort;
    if (n_new >= 0) begin
      g_log.push_back(n_new);
      g_cyc.push_back(cyc);
    end
    if (xo >= 0) begin
      s_pos[xo]++;
      if (xl || n_abort) begin
        s_act[xo] = 1'b0;
        if (s_auto[xo] > 0) start(xo, s_auto[xo], 1'b0);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (Rst) s_act[i] = 1'b0;
      if (s_hold[i] > 0) s_hold[i]--;
      if (rnd_mode) begin
        if (!s_act[i] && $urandom_range(0, 7) == 0)
          start(i, int'($urandom_range(1, 80)), $urandom_range(0, 9) == 0);
        else if (s_act[i] && s_hold[i] == 0 && $urandom_range(0, 15) == 0)
          s_hold[i] = int'($urandom_range(1, 4));
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic wait_idle(input int lim);
    bit busy_now;
    busy_now = 1'b1;
    for (int k = 0; k < lim && busy_now; k++) begin
      cycle();
      busy_now = (m_own >= 0) || (m_quiet > 0);
      for (int i = 0; i < N; i++) if (s_act[i]) busy_now = 1'b1;
    end
    chk("idle_timeout", busy_now, 1'b0);
  endtask

  initial begin
    int base, ab0;
    n_chk = 0; n_pass = 0; cyc = 0; rdy_pulses = 0; ab_cnt = 0;
    rdy_mode = 0; rnd_mode = 1'b0; Rst = 1'b1; Tx_Rdy = 1'b1;
    for (int i = 0; i < N; i++) begin
      s_act[i] = 1'b0; s_hold[i] = 0; s_auto[i] = 0; s_len[i] = 1;
      s_pos[i] = 0; s_base[i] = 0; s_nolast[i] = 1'b0;
    end
    m_own = -1; m_cnt = 0; m_quiet = 0; m_ptr = N - 1; m_abort = 1'b0;
    drive();
    @(posedge Clk);
    #1;
    run(3);
    Rst = 1'b0;

    // Single 64-byte frame from requester 0, then a full gap.
    start(0, 64, 1'b0);
    wait_idle(300);

    // Requesters 0 and 1 stream 60-byte frames; pointer sits at 0, so 1 leads.
    base = g_log.size();
    s_auto[0] = 60; s_auto[1] = 60;
    start(0, 60, 1'b0); start(1, 60, 1'b0);
    run(4 * (60 + IPG + 1) + 5);
    s_auto[0] = 0; s_auto[1] = 0;
    wait_idle(400);
    chk("rr_count", g_log.size() >= base + 4, 1'b1);
    for (int k = 0; k < 4; k++) chk("rr_order", g_log[base + k], (k % 2 == 0) ? 1 : 0);
    for (int k = 1; k < 4; k++) chk("rr_spacing", g_cyc[base + k] - g_cyc[base + k - 1], 60 + IPG + 1);

    // Tx_Rdy toggling on a 10-byte frame.
    rdy_mode = 1; rdy_pulses = 0;
    start(0, 10, 1'b0);
    wait_idle(200);
    chk("rdy_pulses", rdy_pulses, 10);
    rdy_mode = 0;

    // Owner pauses 5 cycles mid-frame while requester 1 asks.
    start(0, 30, 1'b0);
    for (int k = 0; k < 200 && s_pos[0] < 10; k++) cycle();
    s_hold[0] = 5;
    start(1, 12, 1'b0);
    run(5);
    chk("hold_grant", Grant, 3'b001);
    wait_idle(400);

    // Frame with no last byte is cut at MAXB; a last byte exactly at MAXB is not.
    ab0 = ab_cnt;
    start(2, 100, 1'b1);
    wait_idle(300);
    chk("abort_pulses", ab_cnt - ab0, 1);
    ab0 = ab_cnt;
    start(1, MAXB, 1'b0);
    wait_idle(300);
    chk("edge_no_abort", ab_cnt - ab0, 0);

    // Reset mid-frame, then all three request together.
    start(1, 40, 1'b0);
    for (int k = 0; k < 200 && s_pos[1] < 20; k++) cycle();
    Rst = 1'b1;
    cycle();
    chk("rst_grant", Grant, 3'b000);
    chk("rst_txvld", Tx_Vld, 1'b0);
    chk("rst_abort", Tx_Abort, 1'b0);
    Rst = 1'b0;
    base = g_log.size();
    start(0, 8, 1'b0); start(1, 8, 1'b0); start(2, 8, 1'b0);
    wait_idle(600);
    chk("rst_first_winner", g_log[base], 0);
    chk("rst_second_winner", g_log[base + 1], 1);

    // Random traffic with random stalls and source pauses.
    rnd_mode = 1'b1; rdy_mode = 2;
    run(2500);
    rnd_mode = 1'b0;
    wait_idle(2000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
